// File: rtl/downscale_pkg.sv
// Shared definitions for the box-average downscaler.
// Holds the width helpers, the reciprocal function that builds the
// per-window-width scale ROM, and the packed column type.
package downscale_pkg;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_N_LINES     = 15;
  localparam int DEF_N_COLS      = 20;
  localparam int DEF_RECIP_SHIFT = 24;

  // Column type for the default configuration: line i at bits [i*DATA_W +: DATA_W]
  typedef logic [DEF_N_LINES*DEF_DATA_W-1:0] column_t;

  // Width of one column sum (N_LINES pixels)
  function automatic int col_w(input int data_w, input int n_lines);
    return data_w + $clog2(n_lines);
  endfunction

  // Width of a full window sum (N_COLS column sums)
  function automatic int sum_w(input int data_w, input int n_lines, input int n_cols);
    return col_w(data_w, n_lines) + $clog2(n_cols);
  endfunction

  // Width of the window sum times its fixed-point reciprocal
  function automatic int prod_w(input int data_w, input int n_lines, input int n_cols,
                                input int shift);
    return sum_w(data_w, n_lines, n_cols) + shift;
  endfunction

  // ceil(2^shift / (n_lines*k)); rounding up lets a flat window reproduce its value under truncation
  function automatic longint unsigned recip_ceil(input int n_lines, input int k, input int shift);
    longint unsigned num;
    longint unsigned den;
    if (k <= 0 || n_lines <= 0) return 64'd0;
    num = 64'd1 << shift;
    den = 64'(n_lines) * 64'(k);
    return (num + den - 64'd1) / den;
  endfunction

endpackage

// File: rtl/column_adder_tree.sv
// Registered sum of the N_LINES pixels of one input column.
// The sum is captured only when the pipeline enable is high.
module column_adder_tree
  import downscale_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int N_LINES = 15
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en_i,
  input  logic [N_LINES*DATA_W-1:0]         lines_i,
  output logic [col_w(DATA_W, N_LINES)-1:0] sum_o
);

  localparam int COL_W = col_w(DATA_W, N_LINES);

  logic [COL_W-1:0] sum_d;
  logic [COL_W-1:0] sum_q;

  // Combinational sum of all lines of the column
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N_LINES; i++) begin
      sum_d = sum_d + COL_W'(lines_i[i*DATA_W +: DATA_W]);
    end
  end

  // Column sum register, frozen while the pipeline is stalled
  always_ff @(posedge clk) begin
    if (!rst_n)    sum_q <= '0;
    else if (en_i) sum_q <= sum_d;
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/box_avg_downscaler.sv
// Box-filter downscaler: averages an N_LINES x N_COLS window into one pixel.
// Pipeline: S0 column sum, S1 window accumulate, S2 reciprocal multiply, S3 shift/saturate.
// A single enable (output free or being taken) advances or freezes every stage.
// Optional build macro DOWNSCALE_ROUND_EN: round-half-up before the shift
// (undefined: truncate).
module box_avg_downscaler
  import downscale_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int N_LINES     = 15,
  parameter int N_COLS      = 20,
  parameter int RECIP_SHIFT = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_LINES*DATA_W-1:0] in_lines,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_partial
);

  localparam int COL_W  = col_w(DATA_W, N_LINES);
  localparam int SUM_W  = sum_w(DATA_W, N_LINES, N_COLS);
  localparam int PROD_W = prod_w(DATA_W, N_LINES, N_COLS, RECIP_SHIFT);
  localparam int K_W    = $clog2(N_COLS + 1);
  localparam logic [DATA_W-1:0] PIX_MAX = '1;

  logic              en;
  logic              accept;
  logic              close_now;
  logic [K_W-1:0]    col_cnt_d, col_cnt_q;

  logic [COL_W-1:0]  s0_sum;
  logic              s0_valid_q, s0_close_q;
  logic [K_W-1:0]    s0_k_q;

  logic [SUM_W-1:0]  acc_sum;
  logic [SUM_W-1:0]  acc_d, acc_q, total_d, total_q;
  logic [K_W-1:0]    k_d, k_q;
  logic              tvalid_d, tvalid_q;

  logic [PROD_W-1:0] recip;
  logic [PROD_W-1:0] prod_d, prod_q;
  logic              s2_partial_d, s2_partial_q, pvalid_q;

  logic [PROD_W-1:0] rounded, scaled;
  logic [DATA_W-1:0] pix;
  logic              out_valid_q, out_partial_q;
  logic [DATA_W-1:0] out_data_q;

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign accept    = in_valid && en;
  assign close_now = in_last || (col_cnt_q == K_W'(N_COLS - 1));

  // Column position inside the current window; wraps on the closing column
  always_comb begin
    col_cnt_d = col_cnt_q;
    if (accept) col_cnt_d = close_now ? '0 : col_cnt_q + K_W'(1);
  end

  // Column counter register
  always_ff @(posedge clk) begin
    if (!rst_n) col_cnt_q <= '0;
    else        col_cnt_q <= col_cnt_d;
  end

  column_adder_tree #(
    .DATA_W  (DATA_W),
    .N_LINES (N_LINES)
  ) u_col_sum (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en),
    .lines_i (in_lines),
    .sum_o   (s0_sum)
  );

  // S0 side-band: valid, window width so far and window-close flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_valid_q <= 1'b0;
      s0_k_q     <= '0;
      s0_close_q <= 1'b0;
    end else if (en) begin
      s0_valid_q <= in_valid;
      s0_k_q     <= col_cnt_q + K_W'(1);
      s0_close_q <= close_now;
    end
  end

  // S1: accumulate column sums; on close hand the window total onward and restart
  always_comb begin
    acc_sum  = acc_q + SUM_W'(s0_sum);
    acc_d    = acc_q;
    total_d  = total_q;
    k_d      = k_q;
    tvalid_d = 1'b0;
    if (s0_valid_q) begin
      if (s0_close_q) begin
        total_d  = acc_sum;
        k_d      = s0_k_q;
        acc_d    = '0;
        tvalid_d = 1'b1;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  // S1 registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      total_q  <= '0;
      k_q      <= '0;
      tvalid_q <= 1'b0;
    end else if (en) begin
      acc_q    <= acc_d;
      total_q  <= total_d;
      k_q      <= k_d;
      tvalid_q <= tvalid_d;
    end
  end

  // Reciprocal ROM, one constant per window width 1..N_COLS
  always_comb begin
    recip = '0;
    for (int i = 1; i <= N_COLS; i++) begin
      if (k_q == K_W'(i)) recip = PROD_W'(recip_ceil(N_LINES, i, RECIP_SHIFT));
    end
  end

  // S2 next-state: scale the window total and note whether the window was short
  always_comb begin
    prod_d       = PROD_W'(total_q) * recip;
    s2_partial_d = (k_q != K_W'(N_COLS));
  end

  // S2 registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_q       <= '0;
      s2_partial_q <= 1'b0;
      pvalid_q     <= 1'b0;
    end else if (en) begin
      prod_q       <= prod_d;
      s2_partial_q <= s2_partial_d;
      pvalid_q     <= tvalid_q;
    end
  end

  // S3 datapath: optional half-LSB rounding, drop fraction bits, clamp to pixel range
  always_comb begin
`ifdef DOWNSCALE_ROUND_EN
    rounded = prod_q + (PROD_W'(1) << (RECIP_SHIFT - 1));
`else
    rounded = prod_q;
`endif
    scaled = rounded >> RECIP_SHIFT;
    pix    = (scaled > PROD_W'(PIX_MAX)) ? PIX_MAX : DATA_W'(scaled);
  end

  // Output register; data holds while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_partial_q <= 1'b0;
    end else if (en) begin
      out_valid_q <= pvalid_q;
      if (pvalid_q) begin
        out_data_q    <= pix;
        out_partial_q <= s2_partial_q;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_partial = out_partial_q;

endmodule

// File: tb/tb_box_avg_downscaler.sv
// Self-checking bench for box_avg_downscaler (default parameters).
// A reference model works on whole windows: it sums accepted columns,
// closes on in_last or the N_COLS-th column and predicts {partial, pixel}.
module tb_box_avg_downscaler;
  import downscale_pkg::*;

  localparam int DATA_W      = DEF_DATA_W;
  localparam int N_LINES     = DEF_N_LINES;
  localparam int N_COLS      = DEF_N_COLS;
  localparam int RECIP_SHIFT = DEF_RECIP_SHIFT;
  localparam int LW          = N_LINES * DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  column_t           in_lines = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic              out_partial;

  int checks = 0;
  int errors = 0;

  logic [DATA_W:0] expQ[$];
  logic [DATA_W:0] obsQ[$];
  longint winSum = 0;
  int     winK = 0;
  int     cyc = 0;
  int     closeCyc = 0;
  int     riseCyc = 0;
  logic   prevValid = 1'b0;
  logic   streamDone;

  always #5 clk = ~clk;

  box_avg_downscaler #(
    .DATA_W      (DATA_W),
    .N_LINES     (N_LINES),
    .N_COLS      (N_COLS),
    .RECIP_SHIFT (RECIP_SHIFT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_lines    (in_lines),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_partial (out_partial)
  );

  // Window average from the scaling rule: total * ceil(2^S/(N*k)) >> S, clamped
  function automatic logic [DATA_W:0] model_pixel(input longint total, input int k);
    longint den, rcp, p;
    logic [DATA_W-1:0] v;
    den = longint'(N_LINES) * longint'(k);
    rcp = ((longint'(1) << RECIP_SHIFT) + den - 1) / den;
    p   = total * rcp;
`ifdef DOWNSCALE_ROUND_EN
    p = p + (longint'(1) << (RECIP_SHIFT - 1));
`endif
    p = p >> RECIP_SHIFT;
    if (p > longint'((1 << DATA_W) - 1)) p = longint'((1 << DATA_W) - 1);
    v = DATA_W'(p);
    return {(k != N_COLS), v};
  endfunction

  function automatic longint column_total(input column_t c);
    longint s = 0;
    for (int i = 0; i < N_LINES; i++) s += longint'(c[i*DATA_W +: DATA_W]);
    return s;
  endfunction

  function automatic column_t flat_col(input logic [DATA_W-1:0] v);
    return {N_LINES{v}};
  endfunction

  function automatic column_t rand_col(input int lo, input int hi);
    column_t c;
    for (int i = 0; i < N_LINES; i++) c[i*DATA_W +: DATA_W] = DATA_W'($urandom_range(hi, lo));
    return c;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and reference model, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      winSum    = 0;
      winK      = 0;
      prevValid = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        winSum += column_total(in_lines);
        winK++;
        if (in_last || winK == N_COLS) begin
          expQ.push_back(model_pixel(winSum, winK));
          winSum   = 0;
          winK     = 0;
          closeCyc = cyc;
        end
      end
      if (out_valid && out_ready) obsQ.push_back({out_partial, out_data});
      if (out_valid && !prevValid) riseCyc = cyc;
      prevValid = out_valid;
    end
  end

  // Drive one column, hold it until accepted; entered and left at posedge+1
  task automatic send_col(input column_t c, input logic last);
    int guard = 0;
    in_valid = 1'b1;
    in_lines = c;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready got %b expected 1 within 1000 cycles", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait until every predicted window has appeared, then let the pipe settle
  task automatic wait_idle();
    int guard = 0;
    while (obsQ.size() < expQ.size() && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    if (obsQ.size() < expQ.size()) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d outputs expected %0d", obsQ.size(), expQ.size());
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_out_data: got %0d expected 0", out_data); end
    checks++;
    if (out_partial !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_partial: got %b expected 0", out_partial); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_full_window();
    for (int c = 0; c < N_COLS; c++) send_col(flat_col(8'd100), c == N_COLS - 1);
    wait_idle();
    checks++;
    if (obsQ.size() != 1) begin
      errors++;
      $display("[TB] FAIL full100_count: got %0d outputs expected 1", obsQ.size());
    end else begin
      checks++;
      if (obsQ[0] !== {1'b0, 8'd100}) begin errors++; $display("[TB] FAIL full100_value: got %h expected %h", obsQ[0], {1'b0, 8'd100}); end
      checks++;
      if (obsQ[0] !== expQ[0]) begin errors++; $display("[TB] FAIL full100_model: got %h expected %h", obsQ[0], expQ[0]); end
      checks++;
      if (riseCyc - closeCyc != 4) begin errors++; $display("[TB] FAIL full100_latency: got %0d expected 4", riseCyc - closeCyc); end
    end
    obsQ.delete();
    expQ.delete();
    for (int c = 0; c < N_COLS; c++) send_col(flat_col(8'd255), 1'b0);
    wait_idle();
    checks++;
    if (obsQ.size() != 1) begin
      errors++;
      $display("[TB] FAIL full255_count: got %0d outputs expected 1", obsQ.size());
    end else begin
      checks++;
      if (obsQ[0] !== {1'b0, 8'd255}) begin errors++; $display("[TB] FAIL full255_value: got %h expected %h", obsQ[0], {1'b0, 8'd255}); end
    end
    obsQ.delete();
    expQ.delete();
  endtask

  task automatic test_early_close();
    for (int c = 0; c < 5; c++) send_col(flat_col(8'd60), c == 4);
    for (int c = 0; c < N_COLS; c++) send_col(flat_col(8'd60), 1'b0);
    send_col(flat_col(8'd200), 1'b1);
    send_col(rand_col(0, 255), 1'b1);
    wait_idle();
    checks++;
    if (obsQ.size() != 4 || expQ.size() != 4) begin
      errors++;
      $display("[TB] FAIL early_count: got %0d outputs expected 4", obsQ.size());
    end else begin
      checks++;
      if (obsQ[0] !== {1'b1, 8'd60}) begin errors++; $display("[TB] FAIL early_k5: got %h expected %h", obsQ[0], {1'b1, 8'd60}); end
      checks++;
      if (obsQ[1] !== {1'b0, 8'd60}) begin errors++; $display("[TB] FAIL early_next_full: got %h expected %h", obsQ[1], {1'b0, 8'd60}); end
      checks++;
      if (obsQ[2] !== {1'b1, 8'd200}) begin errors++; $display("[TB] FAIL early_k1: got %h expected %h", obsQ[2], {1'b1, 8'd200}); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obsQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL early_model[%0d]: got %h expected %h", i, obsQ[i], expQ[i]); end
      end
    end
    obsQ.delete();
    expQ.delete();
  endtask

  task automatic test_rounding();
    logic [DATA_W:0] want;
    column_t c0;
`ifdef DOWNSCALE_ROUND_EN
    want = {1'b0, 8'd1};
`else
    want = {1'b0, 8'd0};
`endif
    c0 = '0;
    c0[DATA_W-1:0] = 8'd150;
    send_col(c0, 1'b0);
    for (int c = 1; c < N_COLS; c++) send_col('0, 1'b0);
    wait_idle();
    checks++;
    if (obsQ.size() != 1) begin
      errors++;
      $display("[TB] FAIL round_count: got %0d outputs expected 1", obsQ.size());
    end else begin
      checks++;
      if (obsQ[0] !== want) begin errors++; $display("[TB] FAIL round_value: got %h expected %h", obsQ[0], want); end
    end
    obsQ.delete();
    expQ.delete();
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] held;
    logic              heldP;
    int guard = 0;
    fork
      begin
        for (int w = 0; w < 5; w++) begin
          int len = $urandom_range(N_COLS, 1);
          for (int c = 0; c < len; c++) send_col(rand_col(0, 255), c == len - 1);
        end
      end
      begin
        while (!out_valid && guard < 500) begin
          @(posedge clk);
          #1;
          guard++;
        end
        checks++;
        if (!out_valid) begin
          errors++;
          $display("[TB] FAIL bp_first_valid: got %b expected 1", out_valid);
        end else begin
          out_ready = 1'b0;
          held  = out_data;
          heldP = out_partial;
          for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
            checks++;
            if (out_valid !== 1'b1 || out_data !== held || out_partial !== heldP) begin
              errors++;
              $display("[TB] FAIL bp_hold[%0d]: got %b/%h/%b expected 1/%h/%b", i, out_valid, out_data, out_partial, held, heldP);
            end
          end
          @(posedge clk);
          #1;
          out_ready = 1'b1;
        end
      end
    join
    wait_idle();
    checks++;
    if (obsQ.size() != expQ.size()) begin
      errors++;
      $display("[TB] FAIL bp_count: got %0d outputs expected %0d", obsQ.size(), expQ.size());
    end
    while (obsQ.size() > 0 && expQ.size() > 0) begin
      logic [DATA_W:0] o, e;
      o = obsQ.pop_front();
      e = expQ.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL bp_order: got %h expected %h", o, e); end
    end
    obsQ.delete();
    expQ.delete();
  endtask

  task automatic test_random();
    streamDone = 1'b0;
    fork
      begin
        for (int w = 0; w < 12; w++) begin
          int len = $urandom_range(N_COLS, 1);
          int lo  = ($urandom_range(1, 0) == 1) ? 200 : 0;
          for (int c = 0; c < len; c++) send_col(rand_col(lo, 255), (c == len - 1) && (len != N_COLS));
        end
        streamDone = 1'b1;
      end
      begin
        while (!streamDone) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(3, 0) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_idle();
    checks++;
    if (obsQ.size() != 12 || expQ.size() != 12) begin
      errors++;
      $display("[TB] FAIL rand_count: got %0d outputs expected 12", obsQ.size());
    end
    while (obsQ.size() > 0 && expQ.size() > 0) begin
      logic [DATA_W:0] o, e;
      o = obsQ.pop_front();
      e = expQ.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL rand_model: got %h expected %h", o, e); end
    end
    obsQ.delete();
    expQ.delete();
  endtask

  task automatic test_reset_mid_window();
    for (int c = 0; c < 7; c++) send_col(rand_col(0, 255), 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid: got %b expected 0", out_valid); end
    for (int c = 0; c < N_COLS; c++) send_col(flat_col(8'd40), 1'b0);
    wait_idle();
    checks++;
    if (obsQ.size() != 1) begin
      errors++;
      $display("[TB] FAIL midrst_count: got %0d outputs expected 1", obsQ.size());
    end else begin
      checks++;
      if (obsQ[0] !== {1'b0, 8'd40}) begin errors++; $display("[TB] FAIL midrst_value: got %h expected %h", obsQ[0], {1'b0, 8'd40}); end
    end
    obsQ.delete();
    expQ.delete();
  endtask

  initial begin
    test_reset();
    test_full_window();
    test_early_close();
    test_rounding();
    test_backpressure();
    test_random();
    test_reset_mid_window();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/box_avg_downscaler.md
# box_avg_downscaler

Parametrised box-filter downscaler: averages an N_LINES × N_COLS pixel window and emits one DATA_W-bit pixel per window. It sits after the line-buffer/window concatenator in the front-end downscale path and accepts one N_LINES-tall pixel column per transfer. Compared with the fixed 15×20, 8-bit unit, it adds:
- a packed parametric input bus
- valid/ready backpressure on both sides
- early window close via `in_last`, with a per-width reciprocal
- saturation on the output

## Interface
- DATA_W, 8, pixel width
- N_LINES, 15, pixels per input column (window height)
- N_COLS, 20, columns per full window (window width)
- RECIP_SHIFT, 24, fixed-point fraction bits of the reciprocal multiplier
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low; clock clk
- in_valid  in  1  column valid
- in_ready  out  1  column accepted when in_valid && in_ready
- in_lines  in  N_LINES*DATA_W  column pixels; line i at bits [i*DATA_W +: DATA_W]
- in_last  in  1  this column closes the current window (row end)
- out_valid  out  1  averaged pixel valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  averaged pixel
- out_partial  out  1  window had fewer than N_COLS columns

## Operation
- Derived widths:
  - COL_W = DATA_W + $clog2(N_LINES)
  - SUM_W = COL_W + $clog2(N_COLS)
  - product width = SUM_W + RECIP_SHIFT
- Global enable: `en = !out_valid || out_ready`; `in_ready = en`. No stage advances when `en` is 0.
- S0 (column): registers `col_sum` (adder tree over N_LINES pixels), `col_k = col_cnt + 1`, and `close = in_last || col_cnt == N_COLS-1`, plus a valid bit.
- Column counter `col_cnt` (0..N_COLS-1):
  - increments on each accepted column
  - returns to 0 on an accepted column with close=1
- S1 (accumulate): `acc += col_sum` on S0 valid. When S0 close=1:
  - `total = acc + col_sum`
  - `k = col_k`, `acc <= 0`
  - total-valid pulses
- S2 (scale):
  - `out_data = sat((total * RECIP[k] [+ 2^(RECIP_SHIFT-1)]) >> RECIP_SHIFT)`
  - `RECIP[k] = ceil(2^RECIP_SHIFT / (N_LINES*k))`
  - saturates to 2^DATA_W-1
  - `out_partial = (k != N_COLS)`
- Ceil reciprocal guarantees that a constant window reproduces its value exactly under truncation.
- `in_last` on column index N_COLS-1 produces a single full window with out_partial=0. It does not produce an extra empty window.
- `in_last` on the first column of a window produces a k=1 window.
- Reset mid-window: all accumulators, counters and valids clear; the partial window is discarded and produces no output.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_partial=0
  - in_ready=1 (out_valid=0)
  - internal valids=0, acc=0, col_cnt=0
- Latency: the closing column is accepted at edge t; out_valid rises after edge t+3 when unstalled.
- Throughput: one column per cycle. A back-to-back next window starts on the cycle after the closing column with no bubble.
- out_data and out_partial stay stable while out_valid && !out_ready.
- Stall freezes all stages. No column is dropped or duplicated.

## Configuration
- DOWNSCALE_ROUND_EN:
  - defined: adds the half-LSB 2^(RECIP_SHIFT-1) before the shift (round-half-up)
  - undefined: truncates
- Saturation is present in both builds.

## Structure
- Package `downscale_pkg`:
  - `clog2`-based width localparam helpers
  - function `recip_ceil(n_lines, k, shift)`
  - packed column typedef helper
- Reciprocal ROM is N_COLS entries, elaborated from `recip_ceil`.
- One sub-module: `column_adder_tree` (parametric N_LINES-input registered sum, COL_W output).

## Test plan
- Full window, defaults: 20 columns, all pixels 100 -> one output 100, out_partial=0, 3 cycles after the 20th accept.
- Full window, all pixels 255 -> out_data 255, no wrap. Total 76500 × 55925 >> 24 = 255.
- Early close: in_last on the 5th column, all pixels 60 -> out_data 60, out_partial=1, col_cnt back to 0. The next 20 columns form a full window.
- Rounding: one window with line_0 = 150 in column 0, all other pixels 0 -> out_data 0 without DOWNSCALE_ROUND_EN, 1 with it.
- Backpressure: hold out_ready=0 for 10 cycles while out_valid=1 and columns stream -> in_ready=0, out_data stable. After release, every window is output exactly once, in order.
- Reset mid-window: assert rst_n=0 after 7 columns, then stream 20 columns of 40 -> single output 40. No output from the aborted 7 columns.
